fetch_sequencer: RTL and testbench

Instruction-fetch controller sitting in front of the combinational, word-addressed instruction ROM (instructmem). It owns the program counter and drives the ROM address. Each fetched word is captured with its PC into a small FIFO fetch queue, which feeds decode through a valid/ready handshake. It also handles redirects (branch/jump resolution with queue flush), backpressure and end-of-memory halt.

---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch controller placed in front of a combinational,
// word-addressed instruction ROM. It owns the program counter, drives the ROM
// address, and captures each fetched word together with its PC into a small
// FIFO fetch queue. The queue feeds decode through a valid/ready handshake.
// The block also handles redirects (which flush the queue), backpressure, and
// the halt at the end of memory.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   start          one-cycle pulse that moves IDLE to RUN
//   imem_addr      byte address to the ROM (always word-aligned; equals pc)
//   imem_instr     ROM read data, combinational from imem_addr
//   redirect_valid redirect request from the branch unit
//   redirect_pc    redirect target
//   fq_valid       head entry of the fetch queue is valid
//   fq_ready       decode accepts the head entry
//   fq_instr       head instruction (holds its last value while the queue is empty)
//   fq_pc          PC of the head instruction (holds its last value while the queue is empty)
//   misalign_err   one-cycle pulse when a redirect target had nonzero bits [1:0]
//   halted         state is HALT and the queue is empty
//   fetch_count    words enqueued since reset, saturating
//
// state  | meaning
// S_IDLE | waiting for start; no fetch; redirects are ignored
// S_RUN  | fetching one word per cycle while the queue has room
// S_HALT | pc past the end of the ROM; the queue drains; a redirect restarts fetch
module fetch_sequencer #(
  parameter int          MEM_SIZE = 1024,
  parameter int          FQ_DEPTH = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_instr,
  output logic [63:0] fq_pc,
  output logic        misalign_err,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  // pc < MEM_SIZE-3 is the same test as pc+3 < MEM_SIZE, but it cannot overflow.
  localparam logic [63:0]   PC_LIMIT = 64'(MEM_SIZE - 3);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [63:0]   pc, pc_nxt;
  logic [31:0]   q_instr [FQ_DEPTH];
  logic [63:0]   q_pc    [FQ_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   last_instr;
  logic [63:0]   last_pc;
  logic          redir, deq, fetch, in_range, tgt_in_range;
  logic [63:0]   tgt_pc;

  assign imem_addr    = pc;
  assign fq_valid     = (count != '0);
  assign fq_instr     = fq_valid ? q_instr[head] : last_instr;
  assign fq_pc        = fq_valid ? q_pc[head]    : last_pc;
  assign halted       = (state == S_HALT) && (count == '0);
  assign redir        = redirect_valid && (state != S_IDLE);
  assign deq          = fq_valid && fq_ready;
  assign in_range     = (pc < PC_LIMIT);
  assign tgt_pc       = {redirect_pc[63:2], 2'b00};
  assign tgt_in_range = (tgt_pc < PC_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fetch     = 1'b0;
    if (redir) begin
      pc_nxt    = tgt_pc;
      state_nxt = tgt_in_range ? S_RUN : S_HALT;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_RUN;
        S_RUN: begin
          if (!in_range) begin
            state_nxt = S_HALT;
          end else if ((count < DEPTH_C) || deq) begin
            // A full queue stalls pc, so the same ROM word is read again next cycle.
            fetch  = 1'b1;
            pc_nxt = pc + 64'd4;
          end
        end
        S_HALT: ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_instr <= '0;
      last_pc    <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      // Shadow of the presented head, so the fq_* outputs hold steady once the queue empties.
      if (fq_valid) begin
        last_instr <= q_instr[head];
        last_pc    <= q_pc[head];
      end
      if (redir) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (fetch) begin
          q_instr[tail] <= imem_instr;
          q_pc[tail]    <= pc;
          tail          <= tail + PW'(1);
        end
        if (deq) head <= head + PW'(1);
        count <= count + {{(CW-1){1'b0}}, fetch} - {{(CW-1){1'b0}}, deq};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      misalign_err <= redir && (redirect_pc[1:0] != 2'b00);
      if (fetch && (fetch_count != 32'hFFFF_FFFF)) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. A queue-based reference model steps once per
// clock; every cycle, all outputs are compared against it. A directed
// preamble precedes a randomized phase.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_instr;
  logic [63:0] fq_pc;
  logic        misalign_err;
  logic        halted;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [256];

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 64'd1024) ? rom[imem_addr[9:2]] : 32'h0;

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_instr(fq_instr), .fq_pc(fq_pc),
    .misalign_err(misalign_err), .halted(halted), .fetch_count(fetch_count)
  );

  typedef struct {logic [31:0] instr; logic [63:0] pc;} ent_t;
  ent_t        m_q[$];
  ent_t        m_last;
  int          m_state;   // 0 idle, 1 run, 2 halt
  logic [63:0] m_pc;
  logic        m_mis;
  longint      m_fc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = '{32'h0, 64'h0};
    m_state = 0;
    m_pc    = 64'h0;
    m_mis   = 1'b0;
    m_fc    = 0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [63:0] rp, input logic rd);
    int pre;
    bit dq;
    pre = m_q.size();
    dq  = (pre > 0) && rd;
    if (pre > 0) m_last = m_q[0];
    if (dq) void'(m_q.pop_front());
    m_mis = 1'b0;
    if (m_state != 0 && rv) begin
      m_q.delete();
      m_pc    = rp & ~64'h3;
      m_mis   = (rp[1:0] != 2'b00);
      m_state = (m_pc <= 64'd1020) ? 1 : 2;
    end else if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (m_state == 1) begin
      if (m_pc > 64'd1020) m_state = 2;
      else if (pre < 2 || dq) begin
        m_q.push_back('{rom[m_pc[9:2]], m_pc});
        m_pc = m_pc + 64'd4;
        if (m_fc < 64'h0FFFF_FFFF) m_fc++;
      end
    end
  endtask

  task automatic check_all();
    bit          ev;
    logic [31:0] ei;
    logic [63:0] ep;
    ev = (m_q.size() > 0);
    ei = ev ? m_q[0].instr : m_last.instr;
    ep = ev ? m_q[0].pc    : m_last.pc;
    check("fq_valid",     64'(fq_valid),     64'(ev));
    check("fq_instr",     64'(fq_instr),     64'(ei));
    check("fq_pc",        fq_pc,             ep);
    check("imem_addr",    imem_addr,         m_pc);
    check("misalign_err", 64'(misalign_err), 64'(m_mis));
    check("halted",       64'(halted),       64'(m_state == 2 && !ev));
    check("fetch_count",  64'(fetch_count),  64'(m_fc));
  endtask

  // Called at a falling edge: drive, compare, advance the model, move to the next falling edge.
  task automatic cyc(input logic s, input logic rv, input logic [63:0] rp, input logic rd);
    start = s; redirect_valid = rv; redirect_pc = rp; fq_ready = rd;
    check_all();
    model_step(s, rv, rp, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 0; redirect_valid = 0; redirect_pc = 0; fq_ready = 0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rp;
    int n;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    do_reset();

    // Redirects in IDLE are ignored; then a streaming fetch with decode always ready.
    cyc(0, 1, 64'h40, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("lat_valid", 64'(fq_valid), 64'd1);
    check("lat_pc0", fq_pc, 64'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Backpressure fills the queue; then drain in order.
    do_reset();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    check("bp_fc", 64'(fetch_count), 64'd2);
    check("bp_addr", imem_addr, 64'h8);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Redirect with a full queue, together with a dequeue.
    do_reset();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 64'h40, 1);
    cyc(0, 0, 0, 1);
    check("redir_pc", fq_pc, 64'h40);
    check("redir_instr", 64'(fq_instr), 64'(rom[16]));
    cyc(0, 1, 64'h42, 1);
    check("mis_pulse", 64'(misalign_err), 64'd1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 64'h400, 1);
    cyc(0, 0, 0, 1);
    check("oor_halted", 64'(halted), 64'd1);
    cyc(0, 1, 64'h8, 1);
    cyc(0, 0, 0, 1);
    check("restart_pc", fq_pc, 64'h8);

    // Run to the end of memory.
    do_reset();
    cyc(1, 0, 0, 1);
    n = 0;
    while (!halted && n < 400) begin
      cyc(0, 0, 0, 1);
      n++;
    end
    check("end_halted", 64'(halted), 64'd1);
    check("end_fc", 64'(fetch_count), 64'd256);
    check("end_addr", imem_addr, 64'd1024);
    check("end_last_pc", fq_pc, 64'd1020);

    // Asynchronous reset mid-run with a full queue.
    do_reset();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(fq_valid), 64'd0);
    check("arst_addr", imem_addr, 64'h0);
    check("arst_fc", 64'(fetch_count), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 64'h80, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Randomized phase.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: rp = {52'h0, 8'($urandom_range(0, 255)), 2'b00};
        5:             rp = {54'h0, 10'($urandom_range(0, 1023))};
        6:             rp = 64'd1024 + 64'($urandom_range(0, 63));
        default:       rp = {$urandom, $urandom};
      endcase
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0), rp,
          ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
